// File: rtl/boot_rom_loader.sv
// boot_rom_loader: boot ROM with a copy engine that streams the image
// into main RAM and holds the CPU until the copy has completed.
module boot_rom_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH = 32,
  parameter int DST_AW = 12,
  parameter logic [DST_AW-1:0] DST_BASE = '0,
  parameter bit AUTO_BOOT = 1'b1,
  parameter INIT_FILE = "bootrom.hex",
  // Word k sits at INIT_IMAGE[k*DATA_W +: DATA_W]; unlisted words read 0.
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              ram_valid,
  input  logic              ram_ready,
  output logic [DST_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              wr_viol
);

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_chk
    $error("boot_rom_loader %s: DEPTH out of range", INIT_FILE);
  end

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_e;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [DST_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              viol_q, viol_d;
  logic              hs;
  logic              load;
  logic              rd;

  function automatic logic [DATA_W-1:0] rom_at(input int unsigned a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == unsigned'(i)) w = INIT_IMAGE[i*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    load       = 1'b0;
    hs         = valid_q & ram_ready;
    unique case (state_q)
      IDLE: load = AUTO_BOOT | start;
      COPY: begin
        if (hs) begin
          if (idx_q == LAST) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else begin
            idx_d      = idx_q + 1'b1;
            ram_addr_d = ram_addr_q + 1'b1;
            wdata_d    = rom_at(32'(idx_q) + 32'd1);
          end
        end
      end
      DONE: load = start;
      default: state_d = IDLE;
    endcase
    // start in COPY is dropped; only IDLE and DONE may (re)load the engine
    if (load) begin
      state_d    = COPY;
      idx_d      = '0;
      valid_d    = 1'b1;
      ram_addr_d = DST_BASE;
      wdata_d    = rom_at(32'd0);
    end
  end

  always_comb begin
    rd     = cs & ~we;
    dout_d = rd ? rom_at(32'(addr)) : dout_q;
    viol_d = viol_q | (cs & we);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      ram_addr_q <= DST_BASE;
      wdata_q    <= '0;
      dout_q     <= '0;
      viol_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      viol_q     <= viol_d;
    end
  end

  assign dout      = dout_q;
  assign ram_valid = valid_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state_q == COPY);
  assign done      = (state_q == DONE);
  assign cpu_hold  = (state_q != DONE);
  assign wr_viol   = viol_q;

endmodule

// File: tb/tb_boot_rom_loader.sv
// tb_boot_rom_loader: two loaders (auto-boot 32 words, manual 20 words)
// checked against a beat-level reference model with random ready and reads.
module tb_boot_rom_loader;

  function automatic logic [32*16-1:0] mk_img(int n);
    logic [32*16-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*16 +: 16] = 16'hA500 + 16'(k);
    return v;
  endfunction

  localparam logic [32*16-1:0] IMG_A = mk_img(32);
  localparam logic [20*16-1:0] IMG_B = IMG_A[20*16-1:0];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start, cs, we, ram_ready;
  logic [1:0]  ram_valid, busy, done, cpu_hold, wr_viol;
  logic [4:0]  addr [2];
  logic [15:0] dout [2];
  logic [11:0] ram_addr [2];
  logic [15:0] ram_wdata [2];

  always #5 clk = ~clk;

  boot_rom_loader #(
    .DEPTH(32), .DST_BASE(12'h100), .AUTO_BOOT(1'b1), .INIT_IMAGE(IMG_A)
  ) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .cs(cs[0]), .we(we[0]),
    .addr(addr[0]), .dout(dout[0]), .ram_valid(ram_valid[0]),
    .ram_ready(ram_ready[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .busy(busy[0]), .done(done[0]),
    .cpu_hold(cpu_hold[0]), .wr_viol(wr_viol[0])
  );

  boot_rom_loader #(
    .DEPTH(20), .DST_BASE(12'h100), .AUTO_BOOT(1'b0), .INIT_IMAGE(IMG_B)
  ) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .cs(cs[1]), .we(we[1]),
    .addr(addr[1]), .dout(dout[1]), .ram_valid(ram_valid[1]),
    .ram_ready(ram_ready[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .busy(busy[1]), .done(done[1]),
    .cpu_hold(cpu_hold[1]), .wr_viol(wr_viol[1])
  );

  int          dep [2] = '{32, 20};
  int          nb [2];
  int          ph [2];
  int          cyc [2];
  int          rmode [2];
  logic [15:0] dm [2];
  bit          vm [2];
  int          wrc [2][4096];
  bit          randcpu;
  int          vec;
  int          errs;

  function automatic logic [15:0] rom_m(int u, int a);
    return (a < dep[u]) ? 16'hA500 + 16'(a) : 16'h0000;
  endfunction

  task automatic chk(string tag, int u, logic [31:0] o, logic [31:0] e);
    vec++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s[u%0d]: got %0h expected %0h", tag, u, o, e);
    end
  endtask

  task automatic clr_ram(int u);
    for (int a = 0; a < 4096; a++) wrc[u][a] = 0;
  endtask

  task automatic check_ram(int u);
    int uniq, tot;
    uniq = 0;
    tot = 0;
    for (int a = 0; a < 4096; a++) begin
      if (wrc[u][a] != 0) uniq++;
      tot += wrc[u][a];
    end
    chk("ram_unique", u, uniq, dep[u]);
    chk("ram_writes", u, tot, dep[u]);
  endtask

  task automatic step();
    bit          hs [2], st [2], rd [2], wr [2];
    int          p [2];
    logic [4:0]  ra [2];
    logic [11:0] pa [2];
    logic [15:0] pd [2];
    for (int u = 0; u < 2; u++) begin
      if (rmode[u] == 0) ram_ready[u] = 1'b1;
      else if (rmode[u] == 1)
        ram_ready[u] = (cyc[u] % 4 == 0) || (cyc[u] % 4 == 3);
      else ram_ready[u] = 1'($urandom_range(0, 1));
      cyc[u]++;
      if (randcpu) begin
        cs[u] = 1'($urandom_range(0, 1));
        we[u] = ($urandom_range(0, 7) == 0);
        addr[u] = 5'($urandom);
      end
      p[u] = ph[u];
      hs[u] = (ph[u] == 1) && ram_ready[u];
      st[u] = start[u];
      rd[u] = cs[u] && !we[u];
      wr[u] = cs[u] && we[u];
      ra[u] = addr[u];
      pa[u] = ram_addr[u];
      pd[u] = ram_wdata[u];
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      if (rd[u]) dm[u] = rom_m(u, int'(ra[u]));
      if (wr[u]) vm[u] = 1'b1;
      chk("dout", u, dout[u], dm[u]);
      chk("wr_viol", u, wr_viol[u], vm[u]);
      if (hs[u]) begin
        chk("beat_addr", u, pa[u], 12'h100 + 12'(nb[u]));
        chk("beat_data", u, pd[u], rom_m(u, nb[u]));
        wrc[u][pa[u]]++;
        nb[u]++;
        if (nb[u] == dep[u]) ph[u] = 2;
      end else if (p[u] == 1) begin
        chk("stall_addr", u, ram_addr[u], pa[u]);
        chk("stall_data", u, ram_wdata[u], pd[u]);
      end
      if ((p[u] == 0 && (u == 0 || st[u])) || (p[u] == 2 && st[u])) begin
        ph[u] = 1;
        nb[u] = 0;
        clr_ram(u);
        chk("entry_addr", u, ram_addr[u], 12'h100);
        chk("entry_data", u, ram_wdata[u], rom_m(u, 0));
      end
      chk("ram_valid", u, ram_valid[u], ph[u] == 1);
      chk("busy", u, busy[u], ph[u] == 1);
      chk("done", u, done[u], ph[u] == 2);
      chk("cpu_hold", u, cpu_hold[u], ph[u] != 2);
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_dout", u, dout[u], 16'h0);
      chk("rst_valid", u, ram_valid[u], 1'b0);
      chk("rst_addr", u, ram_addr[u], 12'h100);
      chk("rst_wdata", u, ram_wdata[u], 16'h0);
      chk("rst_busy", u, busy[u], 1'b0);
      chk("rst_done", u, done[u], 1'b0);
      chk("rst_hold", u, cpu_hold[u], 1'b1);
      chk("rst_viol", u, wr_viol[u], 1'b0);
      ph[u] = 0;
      nb[u] = 0;
      cyc[u] = 0;
      dm[u] = '0;
      vm[u] = 1'b0;
      clr_ram(u);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_until_done(int u, int budget);
    for (int i = 0; i < budget && ph[u] != 2; i++) step();
    chk("copy_done", u, ph[u], 2);
  endtask

  initial begin
    vec = 0;
    errs = 0;
    start = '0;
    cs = '0;
    we = '0;
    ram_ready = '0;
    addr[0] = '0;
    addr[1] = '0;
    rmode[0] = 0;
    rmode[1] = 0;
    randcpu = 1'b0;
    #2;
    do_rst();

    randcpu = 1'b1;
    run_until_done(0, 80);
    chk("t1_beats", 0, nb[0], 32);
    check_ram(0);
    step();
    chk("t1_busy_low", 0, busy[0], 1'b0);
    chk("t1_b_idle_valid", 1, ram_valid[1], 1'b0);
    chk("t1_b_idle_hold", 1, cpu_hold[1], 1'b1);

    do_rst();
    rmode[0] = 1;
    run_until_done(0, 200);
    check_ram(0);

    do_rst();
    rmode[0] = 0;
    for (int i = 0; i < 40 && nb[0] != 10; i++) step();
    chk("t3_at_beat10", 0, nb[0], 10);
    do_rst();
    run_until_done(0, 80);
    chk("t3_beats", 0, nb[0], 32);
    check_ram(0);

    do_rst();
    rmode[1] = 2;
    for (int i = 0; i < 20; i++) step();
    chk("t4_no_start_valid", 1, ram_valid[1], 1'b0);
    chk("t4_no_start_hold", 1, cpu_hold[1], 1'b1);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    chk("t4_busy_after_restart", 1, busy[1], 1'b1);
    run_until_done(1, 300);
    check_ram(1);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    chk("t4_recopy_done", 1, done[1], 1'b0);
    chk("t4_recopy_hold", 1, cpu_hold[1], 1'b1);
    run_until_done(1, 300);
    check_ram(1);

    randcpu = 1'b0;
    cs = '0;
    we = '0;
    do_rst();
    cs[0] = 1'b1;
    addr[0] = 5'd5;
    step();
    chk("rd5", 0, dout[0], 16'hA505);
    cs[0] = 1'b0;
    addr[0] = 5'd9;
    step();
    step();
    chk("rd_hold", 0, dout[0], 16'hA505);
    cs[1] = 1'b1;
    addr[1] = 5'd2;
    step();
    chk("rd_b2", 1, dout[1], 16'hA502);
    addr[1] = 5'd25;
    step();
    chk("rd_b25", 1, dout[1], 16'h0000);
    cs[1] = 1'b0;
    cs[0] = 1'b1;
    we[0] = 1'b1;
    addr[0] = 5'd3;
    step();
    chk("viol_set", 0, wr_viol[0], 1'b1);
    we[0] = 1'b0;
    step();
    chk("rd3_after_wr", 0, dout[0], 16'hA503);
    cs[0] = 1'b0;
    step();
    chk("viol_sticky", 0, wr_viol[0], 1'b1);
    do_rst();
    step();
    chk("viol_cleared", 0, wr_viol[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
